// File: rtl/lcd_scan_if.sv
// lcd_scan_if: framebuffer read port and LCD panel drive signals of lcd_scan
interface lcd_scan_if;
  logic enable, pixel, pix_clk, lcd_cp, lcd_lp, lcd_flm, lcd_m, busy;
  logic [13:0] pix_addr;
  logic [3:0] lcd_d;
  modport master(input enable, pixel, output pix_clk, pix_addr, lcd_d, lcd_cp, lcd_lp, lcd_flm, lcd_m, busy);
  modport slave(output enable, pixel, input pix_clk, pix_addr, lcd_d, lcd_cp, lcd_lp, lcd_flm, lcd_m, busy);
endinterface

// File: rtl/lcd_scan.sv
// lcd_scan: scans a 1bpp framebuffer out to a 4-bit monochrome LCD panel
module lcd_scan #(
  parameter int H_PIX = 160,
  parameter int V_LINES = 80,
  parameter int DIV = 8
) (
  input logic clk,
  input logic reset,
  lcd_scan_if.master bus
);
  localparam int PW = $clog2(DIV);
  localparam int CW = $clog2(H_PIX + 1);
  localparam int RW = $clog2(V_LINES + 1);
  localparam int HALF = DIV / 2;
  typedef enum logic [1:0] {OFF, SCAN, LATCH} state_t;
  state_t state, state_n;
  logic [PW-1:0] ph, ph_n, cp_cnt;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [3:0] sr, nib, d;
  logic [13:0] addr;
  logic slot_end, frame_end, flm, flm_q, m;
  assign slot_end = ph == PW'(DIV - 1);
  assign frame_end = row == RW'(V_LINES - 1);
  assign nib = {sr[2:0], bus.pixel};
  assign flm = state == LATCH && frame_end;
  always_comb begin
    state_n = state;
    ph_n = slot_end ? '0 : ph + 1'b1;
    col_n = col;
    row_n = row;
    if (state == OFF) begin
      ph_n = '0;
      state_n = bus.enable ? SCAN : OFF;
    end else if (slot_end && state == SCAN) begin
      col_n = col + 1'b1;
      state_n = col == CW'(H_PIX - 1) ? LATCH : SCAN;
    end else if (slot_end) begin
      col_n = '0;
      row_n = frame_end ? '0 : row + 1'b1;
      state_n = frame_end && !bus.enable ? OFF : SCAN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OFF;
      ph <= '0;
      col <= '0;
      row <= '0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      col <= col_n;
      row <= row_n;
    end
  end
  // datapath is cleared on entry to OFF so the first idle cycle is already quiet
  always_ff @(posedge clk) begin
    if (reset || state_n == OFF) begin
      sr <= '0;
      d <= '0;
      cp_cnt <= '0;
      addr <= '0;
    end else begin
      if (cp_cnt != '0) cp_cnt <= cp_cnt - 1'b1;
      if (state == SCAN && ph == '0) addr <= 14'(row) * 14'(H_PIX) + 14'(col);
      if (state == SCAN && ph == PW'(3)) begin
        sr <= nib;
        if (col[1:0] == 2'd3) begin
          d <= nib;
          cp_cnt <= PW'(HALF + 1);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      flm_q <= 1'b0;
      m <= 1'b0;
    end else begin
      flm_q <= flm;
      m <= m ^ (flm_q & ~flm);
    end
  end
  assign bus.pix_clk = state == SCAN && ph == PW'(1);
  assign bus.pix_addr = addr;
  assign bus.lcd_d = d;
  assign bus.lcd_cp = cp_cnt != '0 && cp_cnt <= PW'(HALF);
  assign bus.lcd_lp = state == LATCH && ph != '0 && ph <= PW'(HALF);
  assign bus.lcd_flm = flm;
  assign bus.lcd_m = m;
  assign bus.busy = state != OFF;
endmodule

// File: tb/tb_lcd_scan.sv
// tb_lcd_scan: directed checks of lcd_scan on a 16x6 panel with DIV=8
module tb_lcd_scan;
  localparam int H = 16;
  localparam int V = 6;
  localparam int DIV = 8;
  logic clk, reset, pat, rd;
  logic cp_prev, lp_prev;
  logic [3:0] exp_nib;
  logic [13:0] addr_prev;
  int passed, failed, total;
  int ncp, nlp, nib_bad, seq_bad, clash, cp_len, lp_len, cp_w, lp_w, k;
  lcd_scan_if bus();
  lcd_scan #(.H_PIX(H), .V_LINES(V), .DIV(DIV)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // framebuffer model: data appears two clocks after pix_clk
  always @(posedge clk) begin
    if (bus.pix_clk) rd <= pat ? (bus.pix_addr[1:0] == 2'd0) : 1'b1;
    bus.pixel <= rd;
  end
  function automatic logic [23:0] outs();
    return {bus.busy, bus.pix_clk, bus.lcd_cp, bus.lcd_lp, bus.lcd_flm, bus.lcd_m, bus.lcd_d, bus.pix_addr};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.lcd_cp) cp_len++;
    else begin
      if (cp_len != 0) cp_w = cp_len;
      cp_len = 0;
    end
    if (bus.lcd_lp) lp_len++;
    else begin
      if (lp_len != 0) lp_w = lp_len;
      lp_len = 0;
    end
    if (bus.lcd_cp && !cp_prev) begin
      ncp++;
      if (bus.lcd_d !== exp_nib) nib_bad++;
      if (bus.lcd_lp) clash++;
    end
    if (bus.lcd_lp && !lp_prev) nlp++;
    if (bus.pix_clk && (bus.lcd_lp || bus.lcd_flm)) clash++;
    if (bus.pix_addr != addr_prev && bus.pix_addr != 14'(addr_prev + 1) && bus.pix_addr != '0) seq_bad++;
    cp_prev = bus.lcd_cp;
    lp_prev = bus.lcd_lp;
    addr_prev = bus.pix_addr;
  endtask
  initial begin
    passed = 0; failed = 0; total = 0;
    ncp = 0; nlp = 0; nib_bad = 0; seq_bad = 0; clash = 0;
    cp_len = 0; lp_len = 0; cp_w = 0; lp_w = 0;
    cp_prev = 1'b0; lp_prev = 1'b0; addr_prev = '0;
    reset = 1'b1; bus.enable = 1'b0; pat = 1'b0; rd = 1'b0; exp_nib = 4'hF;
    repeat (3) tick();
    check("reset_outs", outs(), 0);
    reset = 1'b0;
    repeat (3) tick();
    check("off_idle", outs(), 0);
    bus.enable = 1'b1;
    tick();
    check("scan_busy", bus.busy, 1);
    check("first_addr", bus.pix_addr, 0);
    tick();
    check("pix_clk_ph1", bus.pix_clk, 1);
    tick();
    check("pix_clk_ph2", bus.pix_clk, 0);
    k = 2;
    while (!bus.lcd_cp && k < 200) begin tick(); k++; end
    check("cp_latency", k, 3 * DIV + 5);
    check("first_nibble", bus.lcd_d, 4'hF);
    k = 0;
    while (!bus.lcd_lp && k < 400) begin tick(); k++; end
    check("lp_addr", bus.pix_addr, H - 1);
    check("cp_per_line", ncp, H / 4);
    repeat (7) tick();
    check("addr_hold_latch", bus.pix_addr, H - 1);
    tick();
    check("addr_next_line", bus.pix_addr, H);
    check("lp_width", lp_w, DIV / 2);
    check("cp_width", cp_w, DIV / 2);
    k = 0;
    while (!bus.lcd_flm && k < 2000) begin tick(); k++; end
    check("flm_rise_cp", ncp, V * H / 4);
    check("flm_rise_lp", nlp, V - 1);
    check("flm_rise_addr", bus.pix_addr, V * H - 1);
    pat = 1'b1; exp_nib = 4'h8;
    k = 0;
    while (bus.lcd_flm && k < 20) begin tick(); k++; end
    check("flm_width", k, DIV);
    check("frame_lp", nlp, V);
    check("m_before_toggle", {bus.busy, bus.lcd_m}, 2'b10);
    tick();
    check("m_toggled", bus.lcd_m, 1);
    check("addr_wrap", bus.pix_addr, 0);
    ncp = 0; nlp = 0;
    k = 0;
    while (!bus.lcd_lp && k < 400) begin tick(); k++; end
    check("f2_lp_addr", bus.pix_addr, H - 1);
    check("f2_cp_per_line", ncp, H / 4);
    k = 0;
    while (bus.pix_addr != 14'(H) && k < 40) begin tick(); k++; end
    check("f2_addr_next_line", bus.pix_addr, H);
    bus.enable = 1'b0;
    k = 0;
    while (bus.busy && k < 2000) begin tick(); k++; end
    check("drop_full_frame_lp", nlp, V);
    check("drop_full_frame_cp", ncp, V * H / 4);
    tick();
    check("off_outs", outs(), 0);
    check("nibbles", nib_bad, 0);
    check("addr_seq", seq_bad, 0);
    check("latch_clash", clash, 0);
    repeat (5) tick();
    check("off_stays", bus.busy, 0);
    bus.enable = 1'b1;
    tick();
    check("restart_busy", bus.busy, 1);
    bus.enable = 1'b0;
    k = 0;
    while (!bus.lcd_flm && k < 2000) begin tick(); k++; end
    repeat (DIV - 1) tick();
    check("last_latch_cycle", {bus.busy, bus.lcd_flm}, 2'b11);
    bus.enable = 1'b1;
    tick();
    check("reraise_no_off", {bus.busy, bus.lcd_flm}, 2'b10);
    nlp = 0;
    k = 0;
    while (nlp < 3 && k < 1000) begin tick(); k++; end
    repeat (DIV - 2 + 7 * DIV + 6) tick();
    check("cp_before_reset", {bus.lcd_cp, bus.lcd_m}, 2'b11);
    reset = 1'b1;
    tick();
    check("reset_abort", outs(), 0);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_scan", {bus.busy, bus.pix_addr}, 15'h4000);
    tick();
    check("post_reset_ph1", {bus.pix_clk, bus.pix_addr}, 15'h4000);
    repeat (DIV) tick();
    check("post_reset_col1", bus.pix_addr, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
